// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// PipelineHazardController
//
// Stall, bubble and flush sequencer for a 5-stage MIPS pipeline (IF, ID, EX,
// MEM, WB). It sits beside the main control unit. It watches the ID, EX and
// MEM register fields and control bits. From these it drives the PC and IF/ID
// load enables, the per-stage flushes and a global pipeline enable.
//
// Hazards handled, highest priority first:
//   1. data-memory wait state (mem_access without mem_ready)
//   2. taken branch resolved in MEM
//   3. load-use hazard, or an ongoing multi-cycle load-use stall
//
// Parameters
//   LU_STALLS  bubbles inserted per load-use hazard (legal 1..3)
//   CNT_W      width of the saturating stall and flush counters
//
// Ports
//   clock             system clock, rising-edge active
//   reset             synchronous, active-high
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_uses_rt        the ID instruction actually reads rt
//   ex_memRead        instruction in EX is a load
//   ex_rt             destination register of the load in EX
//   mem_branch_taken  branch in MEM is taken
//   mem_access        instruction in MEM reads or writes data memory
//   mem_ready         data memory completes the access this cycle
//   pc_write          PC load enable
//   ifid_write        IF/ID load enable
//   ifid_flush        zero IF/ID at the next edge
//   idex_flush        zero the ID/EX control bits (bubble)
//   exmem_flush       zero the EX/MEM control bits
//   pipe_en           load enable for ID/EX, EX/MEM and MEM/WB
//   stall_count       cycles with pc_write low
//   flush_count       taken-branch flush events
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int LU_STALLS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_en,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // Bubble counter value loaded on a fresh load-use hit. It counts the stall
  // cycles that remain after the one in which the hit is detected.
  localparam logic [1:0] LU_BC = 2'(LU_STALLS - 1);

  state_e           state_q, state_d;
  logic [1:0]       bc_q, bc_d;
  logic             resume_q, resume_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic memWait;
  logic luHit;
  logic inStall;
  logic incStall;
  logic incFlush;

  assign memWait = mem_access & ~mem_ready;
  assign luHit   = ex_memRead & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // A wait state is transparent. While waiting, the controller behaves as if
  // it were still in the state it came from, which the resume flag records.
  // This lets the ready cycle resolve in the same cycle with no extra bubble.
  assign inStall = (state_q == LU_STALL) | ((state_q == MEM_WAIT) & resume_q);

  // Next-state and output decode. The priority order is: wait, then branch,
  // then load-use. Reset forces every output low.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_en     = 1'b0;
    state_d     = state_q;
    bc_d        = bc_q;
    resume_d    = resume_q;
    incStall    = 1'b0;
    incFlush    = 1'b0;

    if (reset) begin
      state_d  = RUN;
      bc_d     = 2'd0;
      resume_d = 1'b0;
    end else if (memWait) begin
      state_d  = MEM_WAIT;
      resume_d = inStall;
      incStall = 1'b1;
    end else if (mem_branch_taken) begin
      // The branch squashes everything younger than MEM. That includes the
      // instruction being held by a load-use stall, so the stall is dropped.
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pipe_en     = 1'b1;
      state_d     = RUN;
      bc_d        = 2'd0;
      resume_d    = 1'b0;
      incFlush    = 1'b1;
    end else if (inStall || luHit) begin
      idex_flush = 1'b1;
      pipe_en    = 1'b1;
      incStall   = 1'b1;
      resume_d   = 1'b0;
      if (inStall) begin
        // The <= also catches a corrupted bc of zero, so the stall cannot
        // lock up.
        bc_d    = bc_q - 2'd1;
        state_d = (bc_q <= 2'd1) ? RUN : LU_STALL;
      end else if (LU_STALLS > 1) begin
        bc_d    = LU_BC;
        state_d = LU_STALL;
      end else begin
        bc_d    = 2'd0;
        state_d = RUN;
      end
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      pipe_en    = 1'b1;
      state_d    = RUN;
      resume_d   = 1'b0;
    end
  end

  // The counters saturate at all-ones, so a long run never wraps them back
  // to small values.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (incStall && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
    if (incFlush && (flushCnt_q != {CNT_W{1'b1}})) begin
      flushCnt_d = flushCnt_q + 1'b1;
    end
  end

  // State and counter registers. Reset is synchronous, and it abandons any
  // stall or wait that is in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      bc_q       <= 2'd0;
      resume_q   <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      resume_q   <= resume_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_count = stallCnt_q;
  assign flush_count = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Drives four controllers from one shared set of stimulus inputs:
//   inst 0..2 : LU_STALLS = 1, 2, 3 with CNT_W = 4 (counters saturate at 15)
//   inst 3    : LU_STALLS = 1 with CNT_W = 16
// A behavioural model counts the remaining stall cycles per instance. It is
// compared against every instance on every falling edge. Hand-computed
// literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  logic       clock;
  logic       reset;
  logic [4:0] idRs, idRt, exRt;
  logic       idUsesRt, exMemRead, memBranchTaken, memAccess, memReady;

  logic pcw   [4];
  logic ifidW [4];
  logic ifidF [4];
  logic idexF [4];
  logic exmemF[4];
  logic pipeE [4];
  logic [3:0]  sc4 [3];
  logic [3:0]  fc4 [3];
  logic [15:0] sc16, fc16;

  int checks   = 0;
  int failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Small-counter instances with LU_STALLS = 1, 2, 3.
  for (genvar g = 0; g < 3; g++) begin : gSmall
    pipeline_hazard_controller #(.LU_STALLS(g + 1), .CNT_W(4)) dut (
      .clock(clock), .reset(reset),
      .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
      .ex_memRead(exMemRead), .ex_rt(exRt),
      .mem_branch_taken(memBranchTaken), .mem_access(memAccess),
      .mem_ready(memReady),
      .pc_write(pcw[g]), .ifid_write(ifidW[g]), .ifid_flush(ifidF[g]),
      .idex_flush(idexF[g]), .exmem_flush(exmemF[g]), .pipe_en(pipeE[g]),
      .stall_count(sc4[g]), .flush_count(fc4[g])
    );
  end

  pipeline_hazard_controller #(.LU_STALLS(1), .CNT_W(16)) dutWide (
    .clock(clock), .reset(reset),
    .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
    .ex_memRead(exMemRead), .ex_rt(exRt),
    .mem_branch_taken(memBranchTaken), .mem_access(memAccess),
    .mem_ready(memReady),
    .pc_write(pcw[3]), .ifid_write(ifidW[3]), .ifid_flush(ifidF[3]),
    .idex_flush(idexF[3]), .exmem_flush(exmemF[3]), .pipe_en(pipeE[3]),
    .stall_count(sc16), .flush_count(fc16)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Model state: stall cycles still owed after the current one. It is kept
  // through wait states, so a wait in the middle of a stall resumes it.
  int luParam [4] = '{1, 2, 3, 1};
  int maxCnt  [4] = '{15, 15, 15, 65535};
  int stallsLeft[4];
  int stallCnt  [4];
  int flushCnt  [4];
  bit modelValid = 1'b0;

  always @(negedge clock) begin
    bit luHitM, memWaitM;
    luHitM   = exMemRead && (exRt != 0) && ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
    memWaitM = memAccess && !memReady;
    for (int g = 0; g < 4; g++) begin
      logic [5:0] expOut, actOut;
      int actSc, actFc;
      bit stalled, flushed;
      stalled = 1'b0;
      flushed = 1'b0;
      // Output vector: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en}
      if (reset)                 expOut = 6'b000000;
      else if (memWaitM)         begin expOut = 6'b000000; stalled = 1'b1; end
      else if (memBranchTaken)   begin expOut = 6'b111111; flushed = 1'b1; end
      else if (stallsLeft[g] > 0 || luHitM) begin expOut = 6'b000101; stalled = 1'b1; end
      else                       expOut = 6'b110001;
      actOut = {pcw[g], ifidW[g], ifidF[g], idexF[g], exmemF[g], pipeE[g]};
      checkOutput($sformatf("model_outs_inst%0d", g), int'(actOut), int'(expOut));
      if (modelValid) begin
        actSc = (g == 3) ? int'(sc16) : int'(sc4[g]);
        actFc = (g == 3) ? int'(fc16) : int'(fc4[g]);
        checkOutput($sformatf("model_stall_count_inst%0d", g), actSc, stallCnt[g]);
        checkOutput($sformatf("model_flush_count_inst%0d", g), actFc, flushCnt[g]);
      end
      // Advance the model to the state after the coming rising edge.
      if (reset) begin
        stallsLeft[g] = 0;
        stallCnt[g]   = 0;
        flushCnt[g]   = 0;
      end else begin
        if (!memWaitM) begin
          if (memBranchTaken)         stallsLeft[g] = 0;
          else if (stallsLeft[g] > 0) stallsLeft[g] = stallsLeft[g] - 1;
          else if (luHitM)            stallsLeft[g] = luParam[g] - 1;
        end
        if (stalled && stallCnt[g] < maxCnt[g]) stallCnt[g]++;
        if (flushed && flushCnt[g] < maxCnt[g]) flushCnt[g]++;
      end
    end
    if (reset) modelValid = 1'b1;
  end

  // Applies one cycle of inputs just after a rising edge.
  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic memRd, input logic [4:0] eRt,
                               input logic br, input logic acc, input logic rdy);
    @(posedge clock);
    #1;
    reset          = rst;
    idRs           = rs;
    idRt           = rt;
    idUsesRt       = usesRt;
    exMemRead      = memRd;
    exRt           = eRt;
    memBranchTaken = br;
    memAccess      = acc;
    memReady       = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; idRs = '0; idRt = '0; exRt = '0;
    idUsesRt = 1'b0; exMemRead = 1'b0; memBranchTaken = 1'b0;
    memAccess = 1'b0; memReady = 1'b0;

    // Reset state
    doReset();
    @(negedge clock);
    checkOutput("reset_pc_write", int'(pcw[0]), 0);
    checkOutput("reset_pipe_en", int'(pipeE[0]), 0);
    doReset();
    @(negedge clock);
    checkOutput("reset_stall_count", int'(sc4[0]), 0);
    idle(1);
    @(negedge clock);
    checkOutput("run_pc_write", int'(pcw[0]), 1);

    // Load-use with 1, 2 and 3 bubbles
    applyStimulus(0, 8, 0, 0, 1, 8, 0, 0, 0);
    @(negedge clock);
    checkOutput("lu_cyc1_pc_write_i0", int'(pcw[0]), 0);
    checkOutput("lu_cyc1_idex_flush_i0", int'(idexF[0]), 1);
    checkOutput("lu_cyc1_pc_write_i1", int'(pcw[1]), 0);
    idle(1);
    @(negedge clock);
    checkOutput("lu_cyc2_pc_write_i0", int'(pcw[0]), 1);
    checkOutput("lu_cyc2_pc_write_i1", int'(pcw[1]), 0);
    checkOutput("lu_cyc2_pc_write_i2", int'(pcw[2]), 0);
    idle(1);
    @(negedge clock);
    checkOutput("lu_cyc3_pc_write_i1", int'(pcw[1]), 1);
    checkOutput("lu_cyc3_pc_write_i2", int'(pcw[2]), 0);
    idle(1);
    @(negedge clock);
    checkOutput("lu_cyc4_pc_write_i2", int'(pcw[2]), 1);
    checkOutput("lu_stall_count_i0", int'(sc4[0]), 1);
    checkOutput("lu_stall_count_i1", int'(sc4[1]), 2);
    checkOutput("lu_stall_count_i2", int'(sc4[2]), 3);

    // $zero and unused-rt never stall; used rt does
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    checkOutput("zero_reg_no_stall", int'(pcw[0]), 1);
    applyStimulus(0, 1, 9, 0, 1, 9, 0, 0, 0);
    @(negedge clock);
    checkOutput("rt_unused_no_stall", int'(pcw[0]), 1);
    applyStimulus(0, 1, 9, 1, 1, 9, 0, 0, 0);
    @(negedge clock);
    checkOutput("rt_used_stall", int'(pcw[0]), 0);
    idle(3);

    // Taken branch on the 2nd stall cycle (LU_STALLS=3)
    doReset();
    applyStimulus(0, 8, 0, 0, 1, 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clock);
    checkOutput("br_pc_write_i2", int'(pcw[2]), 1);
    checkOutput("br_ifid_flush_i2", int'(ifidF[2]), 1);
    checkOutput("br_idex_flush_i2", int'(idexF[2]), 1);
    checkOutput("br_exmem_flush_i2", int'(exmemF[2]), 1);
    idle(1);
    @(negedge clock);
    checkOutput("br_after_pc_write_i2", int'(pcw[2]), 1);
    checkOutput("br_flush_count_i2", int'(fc4[2]), 1);
    checkOutput("br_stall_count_i2", int'(sc4[2]), 1);

    // Memory wait of 4 cycles, resumed on the ready cycle
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clock);
      checkOutput($sformatf("wait%0d_pipe_en", i), int'(pipeE[0]), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clock);
    checkOutput("ready_pipe_en", int'(pipeE[0]), 1);
    checkOutput("ready_pc_write", int'(pcw[0]), 1);
    idle(1);
    @(negedge clock);
    checkOutput("wait_stall_count", int'(sc4[0]), 4);

    // A wait inside a load-use stall resumes the stall on the ready cycle
    doReset();
    applyStimulus(0, 8, 0, 0, 1, 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clock);
    checkOutput("resume_pc_write_i2", int'(pcw[2]), 0);
    checkOutput("resume_pc_write_i0", int'(pcw[0]), 1);
    idle(3);
    @(negedge clock);
    checkOutput("resume_stall_count_i2", int'(sc4[2]), 5);

    // Reset on the 2nd wait cycle
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clock);
    checkOutput("rst_wait_pipe_en", int'(pipeE[0]), 0);
    idle(1);
    @(negedge clock);
    checkOutput("rst_wait_pc_write", int'(pcw[0]), 1);
    checkOutput("rst_wait_stall_count", int'(sc4[0]), 0);

    // A wait outranks a branch; the branch then flushes on the ready cycle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clock);
    checkOutput("wait_over_br_exmem_flush", int'(exmemF[0]), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
    @(negedge clock);
    checkOutput("br_on_ready_ifid_flush", int'(ifidF[0]), 1);
    idle(1);
    @(negedge clock);
    checkOutput("br_on_ready_flush_count", int'(fc4[0]), 1);

    // Saturation of both counters
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 18; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    @(negedge clock);
    checkOutput("sat_stall_count_i0", int'(sc4[0]), 15);
    checkOutput("sat_stall_count_wide", int'(sc16), 20);
    checkOutput("sat_flush_count_i0", int'(fc4[0]), 15);
    checkOutput("sat_flush_count_wide", int'(fc16), 18);
    idle(2);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences stall, bubble and flush for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Sits beside the main control unit. It watches ID/EX/MEM register fields and control bits, then drives PC/IF-ID write enables, per-stage flushes and a global pipeline enable.
- Handles load-use stalls (configurable length), taken branches resolved in MEM, and data-memory wait states via a ready handshake.
- Keeps saturating performance counters.

Parameters:
- LU_STALLS, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without); legal 1..3.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, sw, beq).
- ex_memRead  in  1  memRead control bit of the instruction in EX.
- ex_rt  in  5  destination rt of the load in EX.
- mem_branch_taken  in  1  branch in MEM is taken (branch AND zero).
- mem_access  in  1  memRead OR memWrite of the instruction in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  zero IF/ID at next edge.
- idex_flush  out  1  zero ID/EX control bits at next edge (bubble).
- exmem_flush  out  1  zero EX/MEM control bits at next edge.
- pipe_en  out  1  load enable for ID/EX, EX/MEM, MEM/WB.
- stall_count  out  CNT_W  cycles with pc_write=0.
- flush_count  out  CNT_W  taken-branch flush events.

Behaviour:
- State machine:
  - States: RUN, LU_STALL, MEM_WAIT.
  - Registers: state and a 2-bit bubble counter bc.
  - Outputs are combinational from state and current inputs. Counters are registered.
- Hazard terms:
  - mem_wait = mem_access & ~mem_ready.
  - lu_hit = ex_memRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Priority each cycle, highest first: mem_wait, then mem_branch_taken, then lu_hit or LU_STALL.
- mem_wait (any state):
  - pc_write=0, ifid_write=0, pipe_en=0; all flushes 0.
  - Next state is MEM_WAIT. bc is held. The prior state is saved in a 1-bit resume flag (LU_STALL or RUN).
- MEM_WAIT with mem_ready=1:
  - Resolve as RUN or LU_STALL per the resume flag, in this same cycle, including branch and lu_hit evaluation.
  - Zero-cycle exit. No extra bubble.
- mem_branch_taken (no mem_wait):
  - pc_write=1 (PC takes the target), ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1, pipe_en=1.
  - Any active LU_STALL is aborted: bc=0, next state RUN.
  - flush_count increments by 1.
- RUN with lu_hit:
  - pc_write=0, ifid_write=0, idex_flush=1, pipe_en=1.
  - If LU_STALLS>1: next state LU_STALL, bc=LU_STALLS-1. Otherwise remain in RUN.
- LU_STALL:
  - Same outputs as the lu_hit stall.
  - bc decrements each cycle. Transition to RUN when bc==1.
  - lu_hit is not re-evaluated while in LU_STALL.
- RUN with no hazard: pc_write=ifid_write=pipe_en=1; all flushes 0.
- Counters:
  - stall_count increments on every cycle with pc_write=0 (mem_wait and load-use cycles).
  - Both counters saturate at all-ones and never wrap.
- Reset:
  - state=RUN, bc=0, resume flag=RUN, both counters 0.
  - Outputs while reset is high: pc_write=0, ifid_write=0, pipe_en=0, all flushes 0.
  - Reset mid-stall or mid-wait abandons it immediately.
- $zero: a load to register 0 never stalls.
- X-safety: all outputs are fully defined for every input combination. No don't-care assignments.

Test Plan:
- Load-use, LU_STALLS=1: ex_memRead=1, ex_rt=8, id_rs=8 for one cycle -> exactly 1 cycle of pc_write=0, idex_flush=1; then RUN; stall_count=1.
- Load-use, LU_STALLS=2: same stimulus -> 2 consecutive stall cycles, state returns to RUN; stall_count=2.
- $zero and rt-unused:
  - ex_rt=0, id_rs=0 -> no stall.
  - ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Taken branch during LU_STALL (LU_STALLS=3): branch asserted on the 2nd stall cycle -> all three flushes=1, pc_write=1; next cycle RUN; flush_count=1, stall_count=1.
- Memory wait: mem_access=1, mem_ready=0 for 4 cycles, then 1 -> pipe_en=0 for 4 cycles; resumes on the ready cycle; stall_count=4. Asserting reset on the 2nd wait cycle returns to RUN with counters 0.
- Saturation, CNT_W=4: 20 wait cycles -> stall_count holds at 15.
